// File: rtl/conv_stream_host.sv
// Stream host for a conv engine: buffers one input vector, streams it to the engine
// over valid/ready, captures the engine's results and reports the run length in cycles.
//
// state | meaning
// IDLE  | host loads xbuf; start accepted once the vector is complete
// SEND  | streaming xbuf to the engine, Y beats captured as they arrive
// RECV  | all X sent, waiting for the remaining Y beats
// DONE  | results readable via rd_addr/rd_data until ack
module conv_stream_host #(
    parameter int T       = 16,
    parameter int X_COUNT = 32,
    parameter int F_COUNT = 10,
    parameter int Y_COUNT = X_COUNT - F_COUNT + 1,
    parameter int ADDR_X  = $clog2(X_COUNT),
    parameter int ADDR_Y  = $clog2(Y_COUNT),
    parameter int CYC_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [T-1:0]      ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              start,
    input  logic              ack,
    output logic [T-1:0]      m_data_out_x,
    output logic              m_valid_x,
    input  logic              m_ready_x,
    input  logic [T-1:0]      s_data_in_y,
    input  logic              s_valid_y,
    output logic              s_ready_y,
    input  logic [ADDR_Y-1:0] rd_addr,
    output logic [T-1:0]      rd_data,
    output logic              busy,
    output logic              done,
    output logic [CYC_W-1:0]  cyc_count
);
    localparam int LDW = $clog2(X_COUNT + 1);
    localparam int RXW = $clog2(Y_COUNT + 1);
    localparam logic [LDW-1:0]    LD_FULL = LDW'(X_COUNT);
    localparam logic [ADDR_X-1:0] TX_LAST = ADDR_X'(X_COUNT - 1);
    localparam logic [RXW-1:0]    RX_FULL = RXW'(Y_COUNT);
    localparam logic [RXW-1:0]    RX_LAST = RXW'(Y_COUNT - 1);
    localparam logic [ADDR_Y:0]   RD_LIM  = (ADDR_Y + 1)'(Y_COUNT);
    localparam logic [CYC_W-1:0]  CYC_MAX = '1;

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t            state, state_nx;
    logic [LDW-1:0]    ld_cnt;
    logic [ADDR_X-1:0] tx_idx;
    logic [RXW-1:0]    rx_idx;
    logic [T-1:0]      xbuf [X_COUNT];
    logic [T-1:0]      ybuf [Y_COUNT];

    logic ld_fire, x_fire, y_fire, x_last, rx_full_nx, start_ok;

    assign ld_fire    = ld_valid & ld_ready;
    assign x_fire     = m_valid_x & m_ready_x;
    assign y_fire     = s_valid_y & s_ready_y;
    assign x_last     = x_fire && (tx_idx == TX_LAST);
    // Counts the Y beat landing this cycle, so the last X and last Y can coincide.
    assign rx_full_nx = (rx_idx == RX_FULL) || (y_fire && (rx_idx == RX_LAST));
    assign start_ok   = (state == IDLE) && start && (ld_cnt == LD_FULL);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_ok) state_nx = SEND;
            SEND: if (x_last) state_nx = rx_full_nx ? DONE : RECV;
            RECV: if (rx_full_nx) state_nx = DONE;
            DONE: if (ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ld_ready  = 1'b0;
        m_valid_x = 1'b0;
        s_ready_y = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: ld_ready = (ld_cnt < LD_FULL);
            SEND: begin
                m_valid_x = 1'b1;
                busy      = 1'b1;
                s_ready_y = (rx_idx < RX_FULL);
            end
            RECV: begin
                busy      = 1'b1;
                s_ready_y = (rx_idx < RX_FULL);
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign m_data_out_x = m_valid_x ? xbuf[tx_idx] : '0;
    assign rd_data      = ({1'b0, rd_addr} < RD_LIM) ? ybuf[rd_addr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt    <= '0;
            tx_idx    <= '0;
            rx_idx    <= '0;
            cyc_count <= '0;
        end else begin
            if (ld_fire) ld_cnt <= ld_cnt + 1'b1;
            if (state == DONE && ack) ld_cnt <= '0;
            if (start_ok) begin
                tx_idx    <= '0;
                rx_idx    <= '0;
                cyc_count <= '0;
            end
            if (x_fire) tx_idx <= tx_idx + 1'b1;
            if (y_fire) rx_idx <= rx_idx + 1'b1;
            if (busy && cyc_count != CYC_MAX) cyc_count <= cyc_count + 1'b1;
        end
    end

    // Buffers hold their contents across reset; writes are only blocked while it is asserted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (ld_fire) xbuf[ld_cnt[ADDR_X-1:0]] <= ld_data;
            if (y_fire)  ybuf[rx_idx[ADDR_Y-1:0]] <= s_data_in_y;
        end
    end
endmodule
